// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported, fixed-latency memory between the
//                CPU instruction-fetch port and the load/store data port.
//                Each requester uses a req/gnt/rvalid handshake. Data
//                accesses win contention, but a starvation counter forces a
//                fetch grant after STARVE_MAX consecutive fetch losses.
//
//  Ports
//    clock, reset          : rising-edge clock, async active-low reset
//    if_req/if_addr        : fetch request, held until if_gnt
//    if_gnt/if_rvalid      : 1-cycle accept / data-valid pulses
//    if_rdata              : fetched instruction word
//    d_req/d_we/d_addr/
//    d_wdata               : load/store request, held until d_gnt
//    d_gnt/d_rvalid        : 1-cycle accept / load-data-or-store-done pulses
//    d_rdata               : load data (unchanged by stores)
//    mem_en/mem_we         : 1-cycle memory strobe and its write qualifier
//    mem_addr/mem_wdata    : held from the arbitration edge to the next issue
//    mem_rdata             : valid MEM_LAT cycles after the mem_en cycle
//    busy                  : high whenever the sequencer is not idle
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_cnt_w    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int c_starve_w = $clog2(STARVE_MAX + 1);

    localparam logic [c_cnt_w-1:0]    c_wait_load  = c_cnt_w'(MEM_LAT - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);
    localparam logic [c_starve_w-1:0] c_starve_one = c_starve_w'(1);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [c_cnt_w-1:0]    r_wait_cnt;
    logic [c_starve_w-1:0] r_starve;
    logic                  r_owner_d;   // 1: current operation belongs to data port
    logic                  r_owner_we;  // 1: current operation is a store

    logic                  w_arb;
    logic                  w_take;
    logic                  w_fetch_forced;
    logic                  w_d_win;
    logic                  w_i_win;
    logic                  w_last_wait;

    // ------------------------------------------------------------------
    // Arbitration decision
    // ------------------------------------------------------------------
    // Requests are only looked at on the edge that closes an IDLE or RESP
    // cycle; during ISSUE/WAIT the request lines are ignored entirely, so a
    // requester holding req high simply queues its next operation.
    always_comb begin
        w_arb          = (r_state == ST_IDLE) || (r_state == ST_RESP);
        w_fetch_forced = if_req && (r_starve == c_starve_max);
        w_d_win        = d_req && !w_fetch_forced;
        w_i_win        = if_req && !w_d_win;
        w_take         = w_arb && (if_req || d_req);
        w_last_wait    = (r_state == ST_WAIT) && (r_wait_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE,
            ST_RESP:  w_state_nxt = w_take ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = (r_wait_cnt == '0) ? ST_RESP : ST_WAIT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Wait-cycle counter: loaded in ISSUE so that WAIT lasts exactly
    // MEM_LAT cycles; the cycle where it reads zero is the one in which
    // mem_rdata is valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= c_wait_load;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------
    // Counts consecutive arbitrations that fetch lost while requesting.
    // Any fetch grant, or any arbitration with no fetch request, clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (w_arb) begin
            if (!if_req || w_i_win) begin
                r_starve <= '0;
            end else if (r_starve != c_starve_max) begin
                r_starve <= r_starve + c_starve_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue-side outputs and operation ownership
    // ------------------------------------------------------------------
    // gnt and mem_en are registered from the arbitration decision so they
    // appear together in the ISSUE cycle. Address/write data are latched on
    // the same edge and held until the next issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r_owner_d  <= 1'b0;
            r_owner_we <= 1'b0;
        end else begin
            if_gnt <= w_take && w_i_win;
            d_gnt  <= w_take && w_d_win;
            mem_en <= w_take;
            mem_we <= w_take && w_d_win && d_we;
            if (w_take) begin
                r_owner_d  <= w_d_win;
                r_owner_we <= w_d_win && d_we;
                if (w_d_win) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response-side outputs
    // ------------------------------------------------------------------
    // The last WAIT cycle captures read data into the owner's register and
    // arms that owner's rvalid for the RESP cycle. Stores leave d_rdata
    // untouched but still produce a completion pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= w_last_wait && !r_owner_d;
            d_rvalid  <= w_last_wait && r_owner_d;
            if (w_last_wait && !r_owner_we) begin
                if (r_owner_d) begin
                    d_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy flag, registered from the next state so it tracks r_state.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter. Directed stimulus
//                pushes expected grants and responses into queues; a monitor
//                on the falling clock edge pops and compares whenever the DUT
//                pulses a gnt or rvalid. A small behavioural memory with
//                MEM_LAT cycles of read latency sits on the memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0, d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Cycle index: value k during the cycle that begins at the k-th edge.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural memory: word at byte address a holds 0x1000_0000 | a,
    // except address 0x4 which holds 0xDEADBEEF.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem  [0:63];
    logic [DATA_W-1:0] pipe [0:MEM_LAT-1];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | (i * 4);
        mem[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
    end

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            pipe[0] <= mem[mem_addr[7:2]];
        end
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[MEM_LAT-1];

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        bit                is_d;
        int                cyc;
        logic [ADDR_W-1:0] addr;
        bit                we;
        logic [DATA_W-1:0] wdata;
    } gnt_t;

    typedef struct {
        bit                is_d;
        int                cyc;
        logic [DATA_W-1:0] data;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    gnt_t ge;
    rsp_t re;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_gnt(input bit is_d, input int c, input logic [ADDR_W-1:0] a,
                           input bit we, input logic [DATA_W-1:0] wd);
        gnt_t e;
        e.is_d = is_d; e.cyc = c; e.addr = a; e.we = we; e.wdata = wd;
        gnt_q.push_back(e);
    endtask

    task automatic exp_rsp(input bit is_d, input int c, input logic [DATA_W-1:0] d);
        rsp_t e;
        e.is_d = is_d; e.cyc = c; e.data = d;
        rsp_q.push_back(e);
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (if_gnt || d_gnt) begin
            if (gnt_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_gnt: got if_gnt=%0b d_gnt=%0b at cycle %0d, required no grant",
                         if_gnt, d_gnt, cyc);
            end else begin
                ge = gnt_q.pop_front();
                check("gnt_owner", {62'd0, if_gnt, d_gnt}, ge.is_d ? 64'd1 : 64'd2);
                check("gnt_cycle", 64'(cyc), 64'(ge.cyc));
                check("gnt_mem_en", {63'd0, mem_en}, 64'd1);
                check("gnt_mem_we", {63'd0, mem_we}, {63'd0, ge.we});
                check("gnt_mem_addr", {32'd0, mem_addr}, {32'd0, ge.addr});
                check("gnt_mem_wdata", {32'd0, mem_wdata}, {32'd0, ge.wdata});
            end
        end else if (mem_en) begin
            n_checks++; n_fail++;
            $display("FAIL stray_mem_en: got mem_en=1 without grant at cycle %0d, required 0", cyc);
        end

        if (if_rvalid || d_rvalid) begin
            if (rsp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_rvalid: got if_rvalid=%0b d_rvalid=%0b at cycle %0d, required none",
                         if_rvalid, d_rvalid, cyc);
            end else begin
                re = rsp_q.pop_front();
                check("rsp_owner", {62'd0, if_rvalid, d_rvalid}, re.is_d ? 64'd1 : 64'd2);
                check("rsp_cycle", 64'(cyc), 64'(re.cyc));
                check("rsp_data", {32'd0, (re.is_d ? d_rdata : if_rdata)}, {32'd0, re.data});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string name);
        check({name, "_ctrl"}, {57'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, 64'd0);
        check({name, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
        check({name, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (gnt_q.size() == 0 && rsp_q.size() == 0 && !busy) return;
            tick();
        end
        n_checks++; n_fail++;
        $display("FAIL %s_timeout: got %0d grants / %0d responses outstanding, required 0",
                 name, gnt_q.size(), rsp_q.size());
        gnt_q.delete();
        rsp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int c0;

    initial begin
        // 1: reset held with random requests, then released with none.
        for (int i = 0; i < 4; i++) begin
            tick();
            if_req  = 1'($urandom_range(0, 1));
            d_req   = 1'($urandom_range(0, 1));
            d_we    = 1'($urandom_range(0, 1));
            if_addr = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            chk_idle("reset_held");
        end
        if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("post_reset");
        end

        // 2: single fetch from 0x4.
        c0 = cyc;
        if_req = 1; if_addr = 32'h4;
        exp_gnt(0, c0 + 1, 32'h4, 0, 32'h0);
        exp_rsp(0, c0 + 4, 32'hDEAD_BEEF);
        tick();
        if_req = 0;
        wait_idle("fetch");

        // 3: store 7 to 0x10; d_rdata stays at its reset value.
        c0 = cyc;
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h7;
        exp_gnt(1, c0 + 1, 32'h10, 1, 32'h7);
        exp_rsp(1, c0 + 4, 32'h0);
        tick();
        d_req = 0; d_we = 0; d_wdata = '0;
        wait_idle("store");

        // 4: contention, both held: D,D,D,D,I,D,D,D,D,I, 4 cycles apart.
        c0 = cyc;
        if_req = 1; if_addr = 32'h8;
        d_req  = 1; d_addr  = 32'hC;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                exp_gnt(0, c0 + 1 + 4 * k, 32'h8, 0, 32'h0);
                exp_rsp(0, c0 + 4 + 4 * k, 32'h1000_0008);
            end else begin
                exp_gnt(1, c0 + 1 + 4 * k, 32'hC, 0, 32'h0);
                exp_rsp(1, c0 + 4 + 4 * k, 32'h1000_000C);
            end
        end
        repeat (37) tick();
        if_req = 0; d_req = 0;
        wait_idle("contention");

        // 5: reset during WAIT drops the load; a new load then completes.
        c0 = cyc;
        d_req = 1; d_addr = 32'h20;
        exp_gnt(1, c0 + 1, 32'h20, 0, 32'h0);
        tick();
        d_req = 0;
        tick();
        reset = 1'b0;
        #1;
        chk_idle("mid_reset");
        tick();
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk_idle("after_mid_reset");
        c0 = cyc;
        d_req = 1; d_addr = 32'h20;
        exp_gnt(1, c0 + 1, 32'h20, 0, 32'h0);
        exp_rsp(1, c0 + 4, 32'h1000_0020);
        tick();
        d_req = 0;
        wait_idle("reload");

        // 6: back-to-back loads from 0x0, 0x4, 0x8 with d_req held.
        c0 = cyc;
        d_req = 1; d_addr = 32'h0;
        exp_gnt(1, c0 + 1, 32'h0, 0, 32'h0);
        exp_rsp(1, c0 + 4, 32'h1000_0000);
        exp_gnt(1, c0 + 5, 32'h4, 0, 32'h0);
        exp_rsp(1, c0 + 8, 32'hDEAD_BEEF);
        exp_gnt(1, c0 + 9, 32'h8, 0, 32'h0);
        exp_rsp(1, c0 + 12, 32'h1000_0008);
        tick();
        d_addr = 32'h4;
        repeat (4) tick();
        d_addr = 32'h8;
        repeat (4) tick();
        d_req = 0;
        wait_idle("back_to_back");

        // Read back the earlier store.
        c0 = cyc;
        d_req = 1; d_addr = 32'h10;
        exp_gnt(1, c0 + 1, 32'h10, 0, 32'h0);
        exp_rsp(1, c0 + 4, 32'h7);
        tick();
        d_req = 0;
        wait_idle("store_readback");

        repeat (3) tick();
        check("final_gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        check("final_rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        check("final_busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
